// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 subordinate memory model serving one transaction at a time.
//   Single-beat and FIXED/INCR/WRAP bursts against an internal 64-bit-word array.
// Ports:
//   CLK, RST_N                   clock (rising edge), async active-low reset
//   mem_aw* / mem_w* / mem_b*    write address, write data, write response channels
//   mem_ar* / mem_r*             read address, read data channels
// Optional feature macro: AXI4_MEM_DECERR_EN
//   Defined: beats outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) respond DECERR, write
//   dropped, rdata 0. Undefined: addresses alias modulo MEM_BYTES.
module axi4_mem_responder #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                ID_W      = 4,
    parameter int                MEM_BYTES = 65536,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h80000000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              mem_awvalid,
    output logic              mem_awready,
    input  logic [ID_W-1:0]   mem_awid,
    input  logic [ADDR_W-1:0] mem_awaddr,
    input  logic [7:0]        mem_awlen,
    input  logic [2:0]        mem_awsize,
    input  logic [1:0]        mem_awburst,
    input  logic              mem_wvalid,
    output logic              mem_wready,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [7:0]        mem_wstrb,
    input  logic              mem_wlast,
    output logic              mem_bvalid,
    input  logic              mem_bready,
    output logic [ID_W-1:0]   mem_bid,
    output logic [1:0]        mem_bresp,
    input  logic              mem_arvalid,
    output logic              mem_arready,
    input  logic [ID_W-1:0]   mem_arid,
    input  logic [ADDR_W-1:0] mem_araddr,
    input  logic [7:0]        mem_arlen,
    input  logic [2:0]        mem_arsize,
    input  logic [1:0]        mem_arburst,
    output logic              mem_rvalid,
    input  logic              mem_rready,
    output logic [ID_W-1:0]   mem_rid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mem_rresp,
    output logic              mem_rlast
);
    localparam int                IDX_W = $clog2(MEM_BYTES / 8);
    localparam logic [1:0]        OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [ADDR_W-1:0] ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WDATA, S_WRESP} state_t;

    logic [DATA_W-1:0] r_mem [MEM_BYTES/8];

    state_t            r_state;
    logic              r_last_wr, r_awready, r_arready, r_wready;
    logic              r_bvalid, r_rvalid, r_rlast;
    logic [ID_W-1:0]   r_bid, r_rid, r_wid;
    logic [1:0]        r_bresp, r_rresp, r_bacc;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_len, r_beat;
    logic              r_err, r_wover;

    function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                                 input logic [1:0] bu, input logic [7:0] ln);
        logic [ADDR_W-1:0] step, mask;
        step = ONE << sz;
        mask = (({{(ADDR_W-8){1'b0}}, ln} + ONE) << sz) - ONE;
        case (bu)
            2'd0:    return a;
            2'd2:    return (a & ~mask) | ((a + step) & mask);
            default: return a + step;
        endcase
    endfunction

    function automatic logic f_err(input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] ln);
        return (sz > 3'd3) ||
               (bu == 2'd2 && !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15));
    endfunction

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    // Response codes are ordered by severity, so the worse one is the larger.
    function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Next read beat: from AR in IDLE (first beat), else advance the current beat.
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_err, w_rd_dec, w_wr_dec, w_w_hs, w_mem_we, w_wlast_bad;
    logic [1:0]        w_rd_resp, w_w_resp;
    logic [DATA_W-1:0] w_rd_data;

    assign w_rd_addr = (r_state == S_IDLE) ? mem_araddr : f_next(r_addr, r_size, r_burst, r_len);
    assign w_rd_err  = (r_state == S_IDLE) ? f_err(mem_arsize, mem_arburst, mem_arlen) : r_err;

`ifdef AXI4_MEM_DECERR_EN
    function automatic logic f_dec(input logic [ADDR_W-1:0] a);
        return (a < BASE_ADDR) || ((a - BASE_ADDR) >= ADDR_W'(MEM_BYTES));
    endfunction
    assign w_rd_dec = f_dec(w_rd_addr);
    assign w_wr_dec = f_dec(r_addr);
`else
    assign w_rd_dec = 1'b0;
    assign w_wr_dec = 1'b0;
`endif

    assign w_rd_resp   = f_worst(w_rd_err ? SLVERR : OKAY, w_rd_dec ? DECERR : OKAY);
    assign w_rd_data   = (w_rd_resp == OKAY) ? r_mem[f_idx(w_rd_addr)] : '0;
    assign w_w_hs      = (r_state == S_WDATA) && mem_wvalid && r_wready;
    assign w_w_resp    = f_worst(r_err ? SLVERR : OKAY, w_wr_dec ? DECERR : OKAY);
    // Beats past awlen are swallowed; erroring beats never touch the array.
    assign w_mem_we    = w_w_hs && !r_wover && (w_w_resp == OKAY);
    assign w_wlast_bad = r_wover || (r_beat != r_len);

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < 8; b++)
                if (mem_wstrb[b]) r_mem[f_idx(r_addr)][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_last_wr <= 1'b0;
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_bid     <= '0;
            r_rid     <= '0;
            r_wid     <= '0;
            r_bresp   <= OKAY;
            r_rresp   <= OKAY;
            r_bacc    <= OKAY;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_wover   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_awready && mem_awvalid) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_last_wr <= 1'b1;
                        r_wid     <= mem_awid;
                        r_addr    <= mem_awaddr;
                        r_size    <= mem_awsize;
                        r_burst   <= mem_awburst;
                        r_len     <= mem_awlen;
                        r_beat    <= '0;
                        r_err     <= f_err(mem_awsize, mem_awburst, mem_awlen);
                        r_wover   <= 1'b0;
                        r_bacc    <= OKAY;
                        r_state   <= S_WDATA;
                    end else if (r_arready && mem_arvalid) begin
                        r_arready <= 1'b0;
                        r_last_wr <= 1'b0;
                        r_rid     <= mem_arid;
                        r_addr    <= mem_araddr;
                        r_size    <= mem_arsize;
                        r_burst   <= mem_arburst;
                        r_len     <= mem_arlen;
                        r_beat    <= '0;
                        r_err     <= w_rd_err;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_resp;
                        r_rlast   <= (mem_arlen == 8'd0);
                        r_state   <= S_RD;
                    end else if (!r_awready && !r_arready) begin
                        // Grant one channel; on a tie take the one not granted last.
                        if (mem_awvalid && (!mem_arvalid || !r_last_wr)) r_awready <= 1'b1;
                        else if (mem_arvalid)                            r_arready <= 1'b1;
                    end
                end
                S_RD: begin
                    if (mem_rready) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            r_addr  <= w_rd_addr;
                            r_rdata <= w_rd_data;
                            r_rresp <= w_rd_resp;
                            r_rlast <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                end
                S_WDATA: begin
                    if (w_w_hs) begin
                        if (!r_wover) r_bacc <= f_worst(r_bacc, w_w_resp);
                        if (mem_wlast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_wid;
                            r_bresp  <= f_worst(f_worst(r_bacc, r_wover ? OKAY : w_w_resp),
                                                w_wlast_bad ? SLVERR : OKAY);
                            r_state  <= S_WRESP;
                        end else begin
                            // Counter saturates at awlen; later beats only set the overrun flag.
                            if (r_beat == r_len) r_wover <= 1'b1;
                            else                 r_beat  <= r_beat + 8'd1;
                            r_addr <= f_next(r_addr, r_size, r_burst, r_len);
                        end
                    end
                end
                S_WRESP: begin
                    if (mem_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_awready = r_awready;
    assign mem_arready = r_arready;
    assign mem_wready  = r_wready;
    assign mem_bvalid  = r_bvalid;
    assign mem_bid     = r_bid;
    assign mem_bresp   = r_bresp;
    assign mem_rvalid  = r_rvalid;
    assign mem_rid     = r_rid;
    assign mem_rdata   = r_rdata;
    assign mem_rresp   = r_rresp;
    assign mem_rlast   = r_rlast;
endmodule
